// File: rtl/fm_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fm_sb_pkg
// Description : Shared types and constants for the FM spy-buffer blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package fm_sb_pkg;

    localparam int sb_mapped_n  = 8;
    localparam int sb_frz_to_w  = 16;
    localparam int sb_ovf_cnt_w = 16;

    typedef enum logic [1:0] {
        FRZ_IDLE    = 2'd0,
        FRZ_WAIT    = 2'd1,
        FRZ_FROZEN  = 2'd2,
        FRZ_TIMEOUT = 2'd3
    } fm_sb_frz_state_t;

endpackage
`default_nettype wire

// File: rtl/fm_sb_status_if.sv
`default_nettype none
// ============================================================================
// Module      : fm_sb_status_if
// Description : Status/monitor bundle between the spy-buffer array and fm_sb_status.
// Revision    : 1.0 - initial release
// ============================================================================
interface fm_sb_status_if #(
    parameter int SB_N      = 8,
    parameter int TIMEOUT_W = 16,
    parameter int OVF_CNT_W = 16
);
    logic [SB_N-1:0]              freeze;
    logic [SB_N-1:0]              freeze_mask;
    logic [SB_N-1:0]              sb_frozen;
    logic [SB_N-1:0]              sb_overflow;
    logic                         status_clear;
    logic [TIMEOUT_W-1:0]         timeout_limit;
    logic                         freeze_done;
    logic                         freeze_timeout;
    logic [1:0]                   frz_state;
    logic [$clog2(SB_N+1)-1:0]    frozen_cnt;
    logic [SB_N-1:0]              overflow_sticky;
    logic [OVF_CNT_W-1:0]         overflow_cnt;

    modport master (
        output freeze, freeze_mask, sb_frozen, sb_overflow, status_clear, timeout_limit,
        input  freeze_done, freeze_timeout, frz_state, frozen_cnt, overflow_sticky, overflow_cnt
    );

    modport slave (
        input  freeze, freeze_mask, sb_frozen, sb_overflow, status_clear, timeout_limit,
        output freeze_done, freeze_timeout, frz_state, frozen_cnt, overflow_sticky, overflow_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fm_sb_popcount.sv
`default_nettype none
// ============================================================================
// Module      : fm_sb_popcount
// Description : Combinational population count of a W-bit vector.
// Revision    : 1.0 - initial release
// ============================================================================
module fm_sb_popcount #(
    parameter int W     = 8,
    parameter int OUT_W = $clog2(W+1)
) (
    input  wire logic [W-1:0]     bits,
    output logic      [OUT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + OUT_W'(bits[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fm_sb_status.sv
`default_nettype none
// ============================================================================
// Module      : fm_sb_status
// Description : Freeze handshake FSM, frozen count and overflow status collector.
// Revision    : 1.0 - initial release
// ============================================================================
module fm_sb_status
    import fm_sb_pkg::*;
#(
    parameter int SB_N      = sb_mapped_n,
    parameter int TIMEOUT_W = sb_frz_to_w,
    parameter int OVF_CNT_W = sb_ovf_cnt_w
) (
    input wire logic        axi_clk,
    input wire logic        axi_reset_n,
    fm_sb_status_if.slave   bus
);

    localparam int CNT_W = $clog2(SB_N+1);

    fm_sb_frz_state_t      r_state, w_state_nxt;
    logic [TIMEOUT_W-1:0]  r_wait_cnt, w_wait_cnt_nxt;
    logic [CNT_W-1:0]      r_frozen_cnt;
    logic [SB_N-1:0]       r_sticky;
    logic [OVF_CNT_W-1:0]  r_ovf_cnt;

    logic [SB_N-1:0]       w_req;
    logic                  w_req_any;
    logic                  w_all_frozen;
    logic                  w_expired;
    logic [CNT_W-1:0]      w_frozen_pop;
    logic [CNT_W-1:0]      w_ovf_pop;
    logic [OVF_CNT_W-1:0]  w_ovf_base;
    logic [OVF_CNT_W:0]    w_ovf_sum;

    assign w_req        = bus.freeze & ~bus.freeze_mask;
    assign w_req_any    = |w_req;
    assign w_all_frozen = ((bus.sb_frozen & w_req) == w_req);
    assign w_expired    = (bus.timeout_limit != '0) &&
                          (r_wait_cnt == bus.timeout_limit - TIMEOUT_W'(1));

    fm_sb_popcount #(.W(SB_N), .OUT_W(CNT_W)) u_pop_frozen (
        .bits  (bus.sb_frozen & ~bus.freeze_mask),
        .count (w_frozen_pop)
    );

    fm_sb_popcount #(.W(SB_N), .OUT_W(CNT_W)) u_pop_ovf (
        .bits  (bus.sb_overflow),
        .count (w_ovf_pop)
    );

    // Clear takes effect before this cycle's events are accumulated.
    assign w_ovf_base = bus.status_clear ? '0 : r_ovf_cnt;
    assign w_ovf_sum  = {1'b0, w_ovf_base} + (OVF_CNT_W+1)'(w_ovf_pop);

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        if (!w_req_any) begin
            w_state_nxt = FRZ_IDLE;
        end else begin
            case (r_state)
                FRZ_IDLE: begin
                    w_state_nxt    = FRZ_WAIT;
                    w_wait_cnt_nxt = '0;
                end
                FRZ_WAIT: begin
                    if (w_all_frozen) begin
                        w_state_nxt = FRZ_FROZEN;
                    end else if (w_expired) begin
                        w_state_nxt = FRZ_TIMEOUT;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + TIMEOUT_W'(1);
                    end
                end
                FRZ_FROZEN: begin
                    if (!w_all_frozen) begin
                        w_state_nxt    = FRZ_WAIT;
                        w_wait_cnt_nxt = '0;
                    end
                end
                FRZ_TIMEOUT: w_state_nxt = FRZ_TIMEOUT;
                default:     w_state_nxt = FRZ_IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_clk) begin
        if (!axi_reset_n) begin
            r_state      <= FRZ_IDLE;
            r_wait_cnt   <= '0;
            r_frozen_cnt <= '0;
            r_sticky     <= '0;
            r_ovf_cnt    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_wait_cnt   <= w_wait_cnt_nxt;
            r_frozen_cnt <= w_frozen_pop;
            r_sticky     <= (bus.status_clear ? '0 : r_sticky) | bus.sb_overflow;
            r_ovf_cnt    <= w_ovf_sum[OVF_CNT_W] ? '1 : w_ovf_sum[OVF_CNT_W-1:0];
        end
    end

    assign bus.freeze_done     = (r_state == FRZ_FROZEN);
    assign bus.freeze_timeout  = (r_state == FRZ_TIMEOUT);
    assign bus.frz_state       = r_state;
    assign bus.frozen_cnt      = r_frozen_cnt;
    assign bus.overflow_sticky = r_sticky;
    assign bus.overflow_cnt    = r_ovf_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fm_sb_status.sv
`default_nettype none
// ============================================================================
// Module      : tb_fm_sb_status
// Description : Randomized scoreboard bench for fm_sb_status against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fm_sb_status;

    localparam int SB_N = 8;

    typedef struct {
        logic        done;
        logic        tmo;
        logic [1:0]  st;
        logic [3:0]  fcnt;
        logic [7:0]  sticky;
        logic [15:0] ocnt;
    } exp_t;

    logic axi_clk = 1'b0;
    logic axi_reset_n;

    fm_sb_status_if #(.SB_N(SB_N), .TIMEOUT_W(16), .OVF_CNT_W(16)) bus ();

    fm_sb_status #(.SB_N(SB_N), .TIMEOUT_W(16), .OVF_CNT_W(16)) dut (
        .axi_clk     (axi_clk),
        .axi_reset_n (axi_reset_n),
        .bus         (bus.slave)
    );

    always #5 axi_clk = ~axi_clk;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   drive_done  = 1'b0;

    // Model state: handshake phase named by its readback code, and how long we have waited.
    int   m_phase  = 0;
    int   m_waited = 0;
    int   m_ocnt   = 0;
    bit [7:0] m_sticky = '0;
    int   m_fcnt   = 0;

    task automatic apply(input bit rstn, input bit [7:0] fr, input bit [7:0] mask,
                         input bit [7:0] frz, input bit [7:0] ovf, input bit clr,
                         input int lim);
        bit [7:0] req;
        exp_t e;
        @(negedge axi_clk);
        axi_reset_n       = rstn;
        bus.freeze        = fr;
        bus.freeze_mask   = mask;
        bus.sb_frozen     = frz;
        bus.sb_overflow   = ovf;
        bus.status_clear  = clr;
        bus.timeout_limit = 16'(lim);
        req = fr & ~mask;
        if (!rstn) begin
            m_phase = 0; m_waited = 0; m_ocnt = 0; m_sticky = '0; m_fcnt = 0;
        end else begin
            if (req == 0) begin
                m_phase = 0;
            end else if (m_phase == 0) begin
                m_phase = 1; m_waited = 0;
            end else if (m_phase == 1) begin
                if ((frz & req) == req)                    m_phase = 2;
                else if (lim != 0 && m_waited + 1 == lim)  m_phase = 3;
                else                                       m_waited = (m_waited + 1) % 65536;
            end else if (m_phase == 2) begin
                if ((frz & req) != req) begin m_phase = 1; m_waited = 0; end
            end
            m_fcnt = $countones(frz & ~mask);
            if (clr) begin m_ocnt = 0; m_sticky = '0; end
            m_ocnt   = m_ocnt + $countones(ovf);
            if (m_ocnt > 65535) m_ocnt = 65535;
            m_sticky = m_sticky | ovf;
        end
        e.done   = (m_phase == 2);
        e.tmo    = (m_phase == 3);
        e.st     = 2'(m_phase);
        e.fcnt   = 4'(m_fcnt);
        e.sticky = m_sticky;
        e.ocnt   = 16'(m_ocnt);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    always @(posedge axi_clk) begin
        #2;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            chk("freeze_done",     32'(bus.freeze_done),     32'(e.done));
            chk("freeze_timeout",  32'(bus.freeze_timeout),  32'(e.tmo));
            chk("frz_state",       32'(bus.frz_state),       32'(e.st));
            chk("frozen_cnt",      32'(bus.frozen_cnt),      32'(e.fcnt));
            chk("overflow_sticky", 32'(bus.overflow_sticky), 32'(e.sticky));
            chk("overflow_cnt",    32'(bus.overflow_cnt),    32'(e.ocnt));
        end
    end

    initial begin
        bit [7:0] fr, mask, frz, req;
        // Reset, then a full-width freeze that is acknowledged two cycles late.
        repeat (2) apply(0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        repeat (2) apply(1, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 0);
        repeat (3) apply(1, 8'hFF, 8'h00, 8'hFF, 8'h00, 0, 0);
        apply(1, 8'h00, 8'h00, 8'hFF, 8'h00, 0, 0);
        // Half masked; only the unmasked half reports frozen.
        repeat (4) apply(1, 8'hFF, 8'h0F, 8'hF0, 8'h00, 0, 0);
        apply(1, 8'h00, 8'h0F, 8'h00, 8'h00, 0, 0);
        // All masked: no handshake.
        repeat (3) apply(1, 8'hFF, 8'hFF, 8'hFF, 8'h00, 0, 4);
        // Timeout of 10, then release; then timeout of 1.
        repeat (14) apply(1, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 10);
        apply(1, 8'hFF, 8'h00, 8'hFF, 8'h00, 0, 10);
        repeat (2) apply(1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 10);
        repeat (4) apply(1, 8'h01, 8'h00, 8'h00, 8'h00, 0, 1);
        apply(1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        // Frozen, then bit 3 drops out.
        repeat (3) apply(1, 8'hFF, 8'h00, 8'hFF, 8'h00, 0, 0);
        repeat (2) apply(1, 8'hFF, 8'h00, 8'hF7, 8'h00, 0, 0);
        // Overflow accumulation and clear with a same-cycle event.
        repeat (4) begin
            apply(1, 8'h00, 8'h00, 8'h00, 8'h03, 0, 0);
            apply(1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        end
        apply(1, 8'h00, 8'h00, 8'h00, 8'h80, 1, 0);
        apply(1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        // Reset in the middle of the wait phase.
        repeat (3) apply(1, 8'hFF, 8'h00, 8'h00, 8'h01, 0, 0);
        apply(0, 8'hFF, 8'h00, 8'h00, 8'h01, 0, 0);
        repeat (2) apply(1, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 0);
        // Drive the overflow counter into saturation and hold it there.
        repeat (8200) apply(1, 8'h00, 8'h00, 8'h00, 8'hFF, 0, 0);
        repeat (3) apply(1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        apply(1, 8'h00, 8'h00, 8'h00, 8'h01, 1, 0);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       fr = 8'h00;
                1:       fr = 8'hFF;
                default: fr = 8'($urandom);
            endcase
            mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            req  = fr & ~mask;
            case ($urandom_range(0, 3))
                0:       frz = req | 8'($urandom);
                1:       frz = 8'h00;
                default: frz = 8'($urandom);
            endcase
            apply(($urandom_range(0, 199) != 0), fr, mask, frz,
                  ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
                  ($urandom_range(0, 31) == 0), $urandom_range(0, 6));
            // Hold the request steady for a while so timeouts can mature.
            repeat ($urandom_range(0, 5))
                apply(1, fr, mask, ($urandom_range(0, 1) == 1) ? frz : 8'($urandom),
                      8'h00, 0, 32'(bus.timeout_limit));
        end
        drive_done = 1'b1;
    end

    initial begin
        int guard;
        guard = 0;
        wait (drive_done == 1'b1);
        while (exp_q.size() != 0 && guard < 10) begin
            @(posedge axi_clk);
            guard++;
        end
        repeat (2) @(posedge axi_clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fm_sb_status.md
# fm_sb_status

Status and monitor collector for the spy-buffer array, returning data in the opposite direction to `fm_sb_ctrl`: control fans freeze and playback commands out, and this block gathers per-spy-buffer status back for the AXI monitor registers. It tracks a global freeze handshake (request, then all unmasked buffers frozen, then done or timeout). It also counts frozen buffers and accumulates overflow events as sticky bits plus a saturating count. It sits beside `fm_sb_ctrl` in the FM top level on the AXI clock domain.

## Interface
Parameters:
- `SB_N`, default `sb_mapped_n`: number of spy buffers monitored.
- `TIMEOUT_W`, default 16: width of the freeze-timeout counter.
- `OVF_CNT_W`, default 16: width of the overflow event counter.

Ports:
- `axi_clk`, in, 1: the single clock.
- `axi_reset_n`, in, 1: reset, synchronous, active-low.
- `freeze`, in, SB_N: commanded freeze vector from `fm_sb_ctrl`.
- `freeze_mask`, in, SB_N: 1 excludes that buffer from the handshake and the frozen count.
- `sb_frozen`, in, SB_N: level, high while the buffer has stopped writing.
- `sb_overflow`, in, SB_N: one-cycle pulse per overflow event.
- `status_clear`, in, 1: pulse that clears the sticky bits and the overflow counter.
- `timeout_limit`, in, TIMEOUT_W: cycles to wait for freeze; 0 disables the timeout.
- `freeze_done`, out, 1: high when all requested buffers are frozen.
- `freeze_timeout`, out, 1: high when the handshake has expired.
- `frz_state`, out, 2: current FSM state, for debug readback.
- `frozen_cnt`, out, $clog2(SB_N+1): number of unmasked buffers currently frozen.
- `overflow_sticky`, out, SB_N: per-buffer sticky overflow flag.
- `overflow_cnt`, out, OVF_CNT_W: total overflow events, saturating.

## Operation
- Define `req = freeze & ~freeze_mask` and `req_any = |req`.
- FSM states and encodings: IDLE=0, WAIT_FRZ=1, FROZEN=2, TIMEOUT=3.
- IDLE:
  - If `req_any`, go to WAIT_FRZ and clear the wait counter.
- WAIT_FRZ:
  - If `(sb_frozen & req) == req`, go to FROZEN.
  - Else if `timeout_limit != 0` and `wait_cnt == timeout_limit-1`, go to TIMEOUT.
  - Otherwise increment `wait_cnt`.
- FROZEN:
  - If any `req` bit loses `sb_frozen`, return to WAIT_FRZ and clear the counter.
- TIMEOUT:
  - Hold until `req_any` drops. Late frozen status does not leave TIMEOUT.
- Any non-IDLE state with `!req_any` goes to IDLE. This takes priority over all other transitions.
- Freeze-condition priority: the all-frozen condition beats timeout in the same cycle.
- Output decode: `freeze_done = (state==FROZEN)` and `freeze_timeout = (state==TIMEOUT)`. Both are decoded from the state register.
- `frozen_cnt` is the registered popcount of `sb_frozen & ~freeze_mask`.
- Overflow, each cycle:
  - `overflow_sticky |= sb_overflow`.
  - `overflow_cnt += popcount(sb_overflow)`, clamped at all-ones. Once saturated it stays there until cleared.
- `status_clear` acts first, then same-cycle events apply. The result is `overflow_sticky = sb_overflow` and `overflow_cnt = popcount(sb_overflow)`. FSM and `frozen_cnt` are unaffected.
- With all buffers masked, `req_any` is 0: the FSM stays in IDLE and `frozen_cnt` is 0.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `freeze_done` 0, `freeze_timeout` 0, `frz_state` 0, `frozen_cnt` 0, `overflow_sticky` 0, `overflow_cnt` 0, `wait_cnt` 0.
- Reset mid-handshake returns the FSM to IDLE on the next edge. The handshake restarts only if `req_any` is still high after reset.
- Latencies:
  - `req_any` rises at cycle N: `frz_state` reads WAIT_FRZ at N+1.
  - All frozen at cycle M: `freeze_done` is high at M+1.
  - `frozen_cnt` and the overflow outputs have 1 cycle of latency.
- With `timeout_limit = L`, `freeze_timeout` is asserted exactly L cycles after WAIT_FRZ is entered. With L=1 it asserts one cycle after entry.
- `freeze` deasserts: `freeze_done` and `freeze_timeout` are low the following cycle.

## Structure
- `fm_sb_pkg` gains:
  - enum `fm_sb_frz_state_t`.
  - constants `sb_frz_to_w` = 16 and `sb_ovf_cnt_w` = 16.
- `fm_sb_popcount`: one combinational sub-module, parameterised on width. It is instantiated twice: once for the frozen count and once for the overflow increment.
- The top level maps these outputs into the FM monitor struct next to `fm_sb_ctrl`.

## Test plan
Bench uses SB_N=8.
- Reset, then freeze=0xFF, mask=0, sb_frozen set two cycles later:
  - `freeze_done` is high 3 cycles after the freeze request.
  - `frozen_cnt` = 8.
- mask=0x0F, freeze=0xFF, sb_frozen=0xF0:
  - `freeze_done` rises.
  - `frozen_cnt` = 4.
- timeout_limit=10, sb_frozen never set:
  - `freeze_timeout` rises exactly 10 cycles after WAIT_FRZ.
  - Dropping freeze gives state IDLE the next cycle.
- In FROZEN, sb_frozen bit 3 drops:
  - state goes to WAIT_FRZ and `freeze_done` goes to 0 the next cycle.
- sb_overflow=0x03 pulses 4 times:
  - cnt = 8 and sticky = 0x03.
  - Then status_clear together with sb_overflow=0x80 gives cnt = 1 and sticky = 0x80.
- Preload to saturation with 0xFF pulses:
  - cnt holds 0xFFFF and does not wrap.
- Reset asserted in WAIT_FRZ:
  - all outputs are zero the next cycle.
